kb_host_tx: RTL and testbench
=============================

Name: kb_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Performs the full PS/2 sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then checks the device acknowledge.
- Drives the open-drain PS/2 lines through pull-low enables. Sits beside the keyboard receive path, which must ignore the bus while o_busy is high.

Parameters:
- SAMPLING_BIT_SIZE, 5, width of the free-running prescaler. A line-sampling tick occurs every 2^SAMPLING_BIT_SIZE clk cycles.
- INHIBIT_CYCLES, 6000, clk cycles the host holds PS/2 clock low (≥100 µs at 50 MHz).
- TIMEOUT_BIT_SIZE, 20, frame-timeout counter width. The timeout fires at 2^TIMEOUT_BIT_SIZE-1 clk cycles.

Ports:
- clk  in  1  system clock
- i_sclr  in  1  synchronous active-high reset
- i_valid  in  1  command byte available
- i_dat  in  8  command byte
- o_ready  out  1  high in IDLE only; a byte is accepted when i_valid & o_ready
- i_ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- i_ps2_dat  in  1  raw PS/2 data line (asynchronous)
- o_ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- o_ps2_dat_oe  out  1  1 = pull PS/2 data low, 0 = release
- o_busy  out  1  high from accept until return to IDLE
- o_done  out  1  one-cycle pulse: frame sent and ACK seen
- o_err  out  1  one-cycle pulse: no ACK, or timeout

Behaviour:
- Reset (i_sclr=1, sampled on the clk edge): state IDLE; all counters cleared; shift register cleared.
  - Output values: o_ready=1, o_busy=0, o_ps2_clk_oe=0, o_ps2_dat_oe=0, o_done=0, o_err=0.
  - Reset mid-frame releases both lines on the next clk edge. No done/err pulse is issued.
- Line sampling:
  - Both PS/2 inputs pass through a 2-FF synchronizer.
  - They are then re-sampled only on prescaler ticks.
  - A falling edge of PS/2 clock (sampled 1 then 0 on consecutive ticks) yields a one-cycle fall_en pulse.
- Accept: in IDLE with i_valid=1, on the next edge:
  - latch i_dat;
  - compute parity = ~^i_dat (odd parity);
  - clear the counter;
  - go to INHIBIT.
  - o_ready drops in the same cycle the state leaves IDLE.
- INHIBIT:
  - o_ps2_clk_oe=1, o_ps2_dat_oe=0.
  - After INHIBIT_CYCLES clk cycles, go to RTS.
- RTS (one cycle): o_ps2_clk_oe=1, o_ps2_dat_oe=1 (start bit 0). Go to TX with bit index 0; the timeout counter is cleared.
- TX:
  - o_ps2_clk_oe=0.
  - Drive frame bit n onto data: oe = ~bit.
  - Frame bits in order: n=0..7 are data LSB first, n=8 is parity, n=9 is stop (released, 1).
  - Start bit stays driven until the first fall_en.
  - Each fall_en advances to the next bit; bits change only on device falling edges.
  - The fall_en that would advance past n=9 moves to ACK with data released.
- ACK: on the next fall_en, sample the synced data line.
  - 0: go to WAIT_IDLE with ack_ok=1.
  - 1: go to WAIT_IDLE with ack_ok=0.
- WAIT_IDLE: once both sampled lines are 1, go to IDLE and pulse o_done if ack_ok, else pulse o_err.
- Timeout: in TX, ACK or WAIT_IDLE, if the counter reaches all ones:
  - release both lines;
  - pulse o_err;
  - go to IDLE.
  - The counter free-runs from RTS exit and does not restart per bit.
- Simultaneous events:
  - fall_en coinciding with the timeout: the timeout wins.
  - i_valid while busy is ignored; the byte is not queued.
- o_done and o_err are never high together. Each frame produces exactly one of them, unless reset.

Test Plan:
- Bench settings: SAMPLING_BIT_SIZE=1, INHIBIT_CYCLES=20, TIMEOUT_BIT_SIZE=10. A device model clocks at 40 clk per half-period.
- Reset values: assert i_sclr 3 cycles → o_ready=1, o_busy=0, both oe=0, no pulses.
- Send 0xED, device ACKs:
  - clock oe high for exactly 20 cycles, then data oe high (start bit);
  - device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - device pulls data low at the 11th fall → single o_done, o_err stays 0.
- Send 0x07 with the device holding data high at ACK → parity bit sampled 0; single o_err, no o_done.
- Device never clocks after RTS → o_err 1023 cycles after RTS exit; both oe=0; o_ready=1.
- Send 0x00 and assert i_sclr after the 4th device falling edge → both oe=0 on the next edge; no done/err; a following 0xFF send completes with o_done.
- Hold i_valid=1 with 0xAA then 0x55 while busy → only 0xAA is transmitted. 0x55 is accepted on the first IDLE cycle only if still valid.

Source files
------------

// File: rtl/kb_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then device acknowledge, through open-drain pull-low enables.
module kb_host_tx #(
  parameter int SAMPLING_BIT_SIZE = 5,
  parameter int INHIBIT_CYCLES    = 6000,
  parameter int TIMEOUT_BIT_SIZE  = 20
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_valid,
  input  logic [7:0] i_dat,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int CNT_W = (TIMEOUT_BIT_SIZE > INH_W) ? TIMEOUT_BIT_SIZE : INH_W;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  // Timeout is registered on the edge where the counter would reach all ones.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((64'd1 << TIMEOUT_BIT_SIZE) - 64'd2);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_TX, S_ACK, S_WAIT_IDLE
  } state_t;

  logic [SAMPLING_BIT_SIZE-1:0] presc;
  logic [1:0]                   clk_sync, dat_sync;
  logic                         clk_smp, dat_smp, fall_en;
  logic                         tick;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic             ack_ok;
  logic             frame_phase;

  assign tick        = &presc;
  assign frame_phase = (state == S_TX) || (state == S_ACK) || (state == S_WAIT_IDLE);

  // Synchronizers and sampled lines reset to the idle-high bus level so that
  // leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      presc    <= '0;
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_smp  <= 1'b1;
      dat_smp  <= 1'b1;
      fall_en  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so the two synchronizer stages really are two flops.
      presc    <= presc + SAMPLING_BIT_SIZE'(1);
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_dat};
      fall_en  <= tick & clk_smp & ~clk_sync[1];
      if (tick) begin
        clk_smp <= clk_sync[1];
        dat_smp <= dat_sync[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      ack_ok       <= 1'b0;
      o_ready      <= 1'b1;
      o_busy       <= 1'b0;
      o_ps2_clk_oe <= 1'b0;
      o_ps2_dat_oe <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (frame_phase && cnt == TO_LAST) begin
        state        <= S_IDLE;
        o_ready      <= 1'b1;
        o_busy       <= 1'b0;
        o_ps2_clk_oe <= 1'b0;
        o_ps2_dat_oe <= 1'b0;
        o_err        <= 1'b1;
      end else begin
        if (frame_phase) cnt <= cnt + CNT_W'(1);
        case (state)
          S_IDLE: begin
            if (i_valid) begin
              shreg        <= {1'b1, ~^i_dat, i_dat};
              cnt          <= '0;
              state        <= S_INHIBIT;
              o_ready      <= 1'b0;
              o_busy       <= 1'b1;
              o_ps2_clk_oe <= 1'b1;
              o_ps2_dat_oe <= 1'b0;
            end
          end
          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              state        <= S_RTS;
              o_ps2_dat_oe <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RTS: begin
            state        <= S_TX;
            o_ps2_clk_oe <= 1'b0;
            bit_cnt      <= '0;
            cnt          <= '0;
          end
          S_TX: begin
            // Start bit stays on the line until the device's first falling edge.
            if (fall_en) begin
              if (bit_cnt == 4'd10) begin
                state        <= S_ACK;
                o_ps2_dat_oe <= 1'b0;
              end else begin
                o_ps2_dat_oe <= ~shreg[0];
                shreg        <= {1'b0, shreg[9:1]};
                bit_cnt      <= bit_cnt + 4'd1;
              end
            end
          end
          S_ACK: begin
            if (fall_en) begin
              ack_ok <= ~dat_smp;
              state  <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (clk_smp && dat_smp) begin
              state   <= S_IDLE;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              o_done  <= ack_ok;
              o_err   <= ~ack_ok;
            end
          end
          default: begin
            state        <= S_IDLE;
            o_ready      <= 1'b1;
            o_busy       <= 1'b0;
            o_ps2_clk_oe <= 1'b0;
            o_ps2_dat_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kb_host_tx.sv
// Bench for kb_host_tx: a PS/2 device model clocks frames out of the host and a
// frame-level reference model supplies the expected bits and outcome.
module tb_kb_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_dat = 8'h00;
  logic       o_ready, o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_err;
  logic       dev_clk_pull = 1'b0;
  logic       dev_dat_pull = 1'b0;
  logic       ps2_clk, ps2_dat;

  int n_checks = 0;
  int n_fail   = 0;

  assign ps2_clk = ~(o_ps2_clk_oe | dev_clk_pull);
  assign ps2_dat = ~(o_ps2_dat_oe | dev_dat_pull);

  kb_host_tx #(
    .SAMPLING_BIT_SIZE(1),
    .INHIBIT_CYCLES   (20),
    .TIMEOUT_BIT_SIZE (10)
  ) dut (
    .clk         (clk),
    .i_sclr      (i_sclr),
    .i_valid     (i_valid),
    .i_dat       (i_dat),
    .o_ready     (o_ready),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_dat   (ps2_dat),
    .o_ps2_clk_oe(o_ps2_clk_oe),
    .o_ps2_dat_oe(o_ps2_dat_oe),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the ten bits a device reads after the start bit.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  task automatic accept(input logic [7:0] d, input bit keep_valid, input string tag);
    int n = 0;
    i_dat   = d;
    i_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!o_busy && n < 50);
    check({tag, "_accept"}, o_busy, 1'b1);
    if (!keep_valid) i_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, then clock; data sampled on each rising edge.
  task automatic dev_frame(input bit ack, input int stop_after, output logic [9:0] bits);
    int n = 0;
    bits = '0;
    while (!(ps2_clk && !ps2_dat) && n < 3000) begin
      step();
      n++;
    end
    for (int k = 1; k <= 12; k++) begin
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk_pull = 1'b1;
      if (k == 11 && ack) dev_dat_pull = 1'b1;
      if (k == stop_after) return;
      repeat (HALF) @(posedge clk);
      #1;
      if (k <= 10) bits[k-1] = ps2_dat;
      dev_clk_pull = 1'b0;
    end
    dev_dat_pull = 1'b0;
  endtask

  task automatic count_pulses(output int nd, output int ne, output logic rdy_at,
                              output logic busy_next);
    int n = 0;
    bit seen = 0;
    nd = 0; ne = 0; rdy_at = 1'b0; busy_next = 1'b0;
    while (!seen && n < 3000) begin
      step();
      n++;
      if (o_done || o_err) begin
        nd += int'(o_done);
        ne += int'(o_err);
        rdy_at = o_ready;
        seen = 1;
      end
    end
    step();
    busy_next = o_busy;
    nd += int'(o_done);
    ne += int'(o_err);
    i_valid = 1'b0;
    repeat (10) begin
      step();
      nd += int'(o_done);
      ne += int'(o_err);
    end
  endtask

  task automatic measure_inhibit(input string tag);
    int n = 0;
    while (o_ps2_clk_oe && !o_ps2_dat_oe && n < 100) begin
      n++;
      step();
    end
    check({tag, "_inhibit_len"}, n, 20);
    check({tag, "_rts_dat_oe"}, o_ps2_dat_oe, 1'b1);
    check({tag, "_rts_clk_oe"}, o_ps2_clk_oe, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit meas_inh,
                           input logic exp_next_busy, input string tag);
    logic [9:0] bits;
    int nd, ne;
    logic rdy_at, busy_next;
    fork
      begin
        if (meas_inh) measure_inhibit(tag);
      end
      dev_frame(ack, 0, bits);
      count_pulses(nd, ne, rdy_at, busy_next);
    join
    check({tag, "_bits"}, bits, frame_bits(d));
    check({tag, "_done_cnt"}, nd, ack ? 1 : 0);
    check({tag, "_err_cnt"}, ne, ack ? 0 : 1);
    check({tag, "_ready_at_end"}, rdy_at, 1'b1);
    check({tag, "_busy_after"}, busy_next, exp_next_busy);
  endtask

  initial begin
    logic [9:0] bits;
    int n, nd, ne;
    logic [7:0] d;
    bit ack;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_clk_oe", o_ps2_clk_oe, 1'b0);
    check("rst_dat_oe", o_ps2_dat_oe, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    i_sclr = 1'b0;
    repeat (5) step();

    accept(8'hED, 0, "ed");
    run_frame(8'hED, 1, 1, 1'b0, "ed");

    accept(8'h07, 0, "nack07");
    run_frame(8'h07, 0, 1, 1'b0, "nack07");
    check("nack07_parity", frame_bits(8'h07) >> 8 & 10'h1, 10'h0);

    // Silent device: frame must time out 1023 cycles after RTS exit.
    accept(8'h3C, 0, "tmo");
    n = 0;
    while (o_ps2_clk_oe && n < 200) begin
      step();
      n++;
    end
    n = 0;
    while (!o_err && n < 2000) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 1023);
    check("tmo_clk_oe", o_ps2_clk_oe, 1'b0);
    check("tmo_dat_oe", o_ps2_dat_oe, 1'b0);
    check("tmo_ready", o_ready, 1'b1);
    check("tmo_no_done", o_done, 1'b0);
    repeat (5) step();

    // Reset in the middle of a frame.
    accept(8'h00, 0, "rstmid");
    nd = 0; ne = 0;
    fork
      begin
        dev_frame(0, 4, bits);
        repeat (10) step();
        check("rstmid_dat_oe_before", o_ps2_dat_oe, 1'b1);
        i_sclr = 1'b1;
        step();
        check("rstmid_clk_oe", o_ps2_clk_oe, 1'b0);
        check("rstmid_dat_oe", o_ps2_dat_oe, 1'b0);
        check("rstmid_ready", o_ready, 1'b1);
        i_sclr = 1'b0;
        dev_clk_pull = 1'b0;
      end
      begin
        repeat (600) begin
          step();
          nd += int'(o_done);
          ne += int'(o_err);
        end
      end
    join
    check("rstmid_no_done", nd, 0);
    check("rstmid_no_err", ne, 0);
    accept(8'hFF, 0, "after_rst");
    run_frame(8'hFF, 1, 1, 1'b0, "after_rst");

    // i_valid held across a frame: the second byte waits for IDLE.
    accept(8'hAA, 1, "hold_aa");
    i_dat = 8'h55;
    run_frame(8'hAA, 1, 1, 1'b1, "hold_aa");
    run_frame(8'h55, 1, 0, 1'b0, "hold_55");

    for (int i = 0; i < 5; i++) begin
      d   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      accept(d, 0, $sformatf("rnd%0d", i));
      run_frame(d, ack, 1, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
